// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter sharing one UART TX core between NUM_REQ sources.
// An owner keeps the transmitter until its last byte completes or its lock times out.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ      = 2,
   parameter int unsigned LOCK_TIMEOUT = 270000
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic [NUM_REQ-1:0]   reqValid,
   input  logic [8*NUM_REQ-1:0] reqData,
   input  logic [NUM_REQ-1:0]   reqLast,
   output logic [NUM_REQ-1:0]   reqReady,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic                 lockTimeout,
   output logic [7:0]           dataToTx,
   output logic                 dataTxStart,
   input  logic                 dataTxActive,
   input  logic                 dataTxDone
);

   localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACTIVE, WAIT_DONE} state_t;

   state_t               state_q, state_d;
   logic [OW-1:0]        owner_q, owner_d;
   logic [OW-1:0]        last_owner_q, last_owner_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic                 last_flag_q, last_flag_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   ready_q, ready_d;
   logic                 timeout_q, timeout_d;
   logic [7:0]           data_q, data_d;
   logic                 start_q, start_d;
   logic                 busy_q, busy_d;

   logic                 pick_valid;
   logic [OW-1:0]        pick_idx;

   // Round-robin scan starting just after the previous owner; the nearest valid requester wins.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int k = int'(NUM_REQ); k >= 1; k--) begin
         if (reqValid[(int'(last_owner_q) + k) % int'(NUM_REQ)]) begin
            pick_valid = 1'b1;
            pick_idx   = OW'((int'(last_owner_q) + k) % int'(NUM_REQ));
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         last_owner_q <= OW'(NUM_REQ - 1);
         timer_q      <= '0;
         last_flag_q  <= 1'b0;
         grant_q      <= '0;
         ready_q      <= '0;
         timeout_q    <= 1'b0;
         data_q       <= 8'h00;
         start_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         timer_q      <= timer_d;
         last_flag_q  <= last_flag_d;
         grant_q      <= grant_d;
         ready_q      <= ready_d;
         timeout_q    <= timeout_d;
         data_q       <= data_d;
         start_q      <= start_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      timer_d      = timer_q;
      last_flag_d  = last_flag_q;
      grant_d      = grant_q;
      ready_d      = '0;
      timeout_d    = 1'b0;
      data_d       = data_q;
      start_d      = start_q;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d = NUM_REQ'(1) << pick_idx;
               owner_d = pick_idx;
               timer_d = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (reqValid[owner_q] && !dataTxActive) begin
               data_d            = reqData[8*owner_q +: 8];
               start_d           = 1'b1;
               ready_d[owner_q]  = 1'b1;
               last_flag_d       = reqLast[owner_q];
               timer_d           = '0;
               state_d           = WAIT_ACTIVE;
            end else if (!reqValid[owner_q] && (LOCK_TIMEOUT > 0)) begin
               // Revoke on the cycle the count reaches LOCK_TIMEOUT; >= keeps it saturating.
               if (timer_q >= TW'(LOCK_TIMEOUT - 1)) begin
                  grant_d      = '0;
                  last_owner_d = owner_q;
                  timeout_d    = 1'b1;
                  timer_d      = '0;
                  state_d      = IDLE;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
         end
         WAIT_ACTIVE: begin
            if (dataTxActive) begin
               start_d = 1'b0;
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (dataTxDone || !dataTxActive) begin
               if (last_flag_q) begin
                  grant_d      = '0;
                  last_owner_d = owner_q;
                  state_d      = IDLE;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign grant       = grant_q;
   assign reqReady    = ready_q;
   assign lockTimeout = timeout_q;
   assign dataToTx    = data_q;
   assign dataTxStart = start_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a UART core model and a TX byte scoreboard.
module tb_uart_tx_arbiter;

   localparam int unsigned NREQ     = 2;
   localparam int unsigned LTO      = 16;
   localparam int unsigned BYTE_CYC = 4;

   logic              clk = 1'b0;
   logic              resetN = 1'b0;
   logic [NREQ-1:0]   reqValid = '0;
   logic [8*NREQ-1:0] reqData = '0;
   logic [NREQ-1:0]   reqLast = '0;
   logic [NREQ-1:0]   reqReady;
   logic [NREQ-1:0]   grant;
   logic              busy;
   logic              lockTimeout;
   logic [7:0]        dataToTx;
   logic              dataTxStart;
   logic              dataTxActive = 1'b0;
   logic              dataTxDone = 1'b0;

   uart_tx_arbiter #(.NUM_REQ(NREQ), .LOCK_TIMEOUT(LTO)) dut (
      .clk(clk), .resetN(resetN), .reqValid(reqValid), .reqData(reqData), .reqLast(reqLast),
      .reqReady(reqReady), .grant(grant), .busy(busy), .lockTimeout(lockTimeout),
      .dataToTx(dataToTx), .dataTxStart(dataTxStart), .dataTxActive(dataTxActive),
      .dataTxDone(dataTxDone)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [7:0] exp_q[$];
   logic [1:0] en = 2'b11;
   int cyc = 0, rdy0 = 0, rdy1 = 0, lto_cnt = 0, lto_cyc = 0, done_cnt = 0, done_cyc = 0;
   int clash = 0, stall_left = 0, core_cnt = 0;
   logic core_busy = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Requester queues, UART core model and scoreboard, all updated 1 time unit after each edge.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (!resetN) begin
         dataTxActive = 1'b0;
         dataTxDone   = 1'b0;
         core_busy    = 1'b0;
      end else begin
         if (reqReady[0]) begin rdy0++; if (q0.size() != 0) void'(q0.pop_front()); end
         if (reqReady[1]) begin rdy1++; if (q1.size() != 0) void'(q1.pop_front()); end
         if (lockTimeout) begin
            lto_cnt++;
            lto_cyc = cyc;
            if (reqReady != '0) clash++;
         end
         dataTxDone = 1'b0;
         if (core_busy) begin
            if (core_cnt > 1) core_cnt--;
            else begin
               core_busy    = 1'b0;
               dataTxActive = 1'b0;
               dataTxDone   = 1'b1;
               done_cnt++;
               done_cyc = cyc + 1;
            end
         end else if (dataTxStart) begin
            if (stall_left > 0) stall_left--;
            else begin
               if (exp_q.size() == 0) check("sb_extra_byte", exp_q.size(), 32'd1);
               else check("tx_byte", dataToTx, exp_q.pop_front());
               dataTxActive = 1'b1;
               core_busy    = 1'b1;
               core_cnt     = BYTE_CYC;
            end
         end
      end
      reqValid[0]  = en[0] && (q0.size() != 0);
      reqData[7:0] = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
      reqLast[0]   = (q0.size() != 0) ? q0[0][8] : 1'b0;
      reqValid[1]  = en[1] && (q1.size() != 0);
      reqData[15:8] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
      reqLast[1]   = (q1.size() != 0) ? q1[0][8] : 1'b0;
   end

   task automatic push_msg(input int req, input string s);
      for (int i = 0; i < s.len(); i++) begin
         logic [8:0] e;
         e = {(i == s.len() - 1), 8'(s[i])};
         if (req == 0) q0.push_back(e); else q1.push_back(e);
         exp_q.push_back(8'(s[i]));
      end
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!busy && q0.size() == 0 && q1.size() == 0 && !core_busy && !dataTxStart) break;
         @(posedge clk); #2;
      end
      check({tag, "_idle"}, {busy, core_busy, dataTxStart}, 3'b000);
      check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      int r_base, bad, d_base, r1_base;
      repeat (3) @(posedge clk);
      #2;
      check("rst_grant", grant, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_start", dataTxStart, 1'b0);
      check("rst_data", dataToTx, 8'h00);
      check("rst_ready", reqReady, 2'b00);
      check("rst_lto", lockTimeout, 1'b0);
      resetN = 1'b1;

      // Reset in the middle of a byte
      push_msg(0, "A");
      for (int i = 0; i < 50 && !dataTxActive; i++) begin @(posedge clk); #2; end
      check("t1_core_active", dataTxActive, 1'b1);
      #1 resetN = 1'b0;
      #1;
      check("t1_start_drop", dataTxStart, 1'b0);
      check("t1_grant_drop", grant, 2'b00);
      check("t1_data_zero", dataToTx, 8'h00);
      q0.delete();
      exp_q.delete();
      repeat (3) @(posedge clk);
      #2 resetN = 1'b1;
      push_msg(1, "R");
      for (int i = 0; i < 20 && grant == 2'b00; i++) begin @(posedge clk); #2; end
      check("t1_grant_req1", grant, 2'b10);
      wait_idle("t1", 200);

      // Simultaneous start of two messages
      rdy0 = 0; rdy1 = 0;
      push_msg(0, "ACK\r\n");
      push_msg(1, "NAK\r\n");
      wait_idle("t2", 500);
      check("t2_ready0", rdy0, 32'd5);
      check("t2_ready1", rdy1, 32'd5);

      // Fairness with single-byte messages
      for (int i = 0; i < 3; i++) begin
         q0.push_back({1'b1, 8'h30});
         q1.push_back({1'b1, 8'h31});
      end
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(8'h30);
         exp_q.push_back(8'h31);
      end
      wait_idle("t3", 500);

      // Lock timeout after an owner goes silent mid-message
      lto_cnt = 0; clash = 0;
      q0.push_back({1'b0, 8'h31});
      exp_q.push_back(8'h31);
      q1.push_back({1'b1, 8'h55});
      exp_q.push_back(8'h55);
      for (int i = 0; i < 200 && lto_cnt == 0; i++) begin @(posedge clk); #2; end
      check("t4_lto_count", lto_cnt, 32'd1);
      check("t4_lto_delay", lto_cyc - done_cyc, 32'd16);
      check("t4_grant_cleared", grant, 2'b00);
      @(posedge clk); #2;
      check("t4_grant_req1", grant, 2'b10);
      wait_idle("t4", 200);
      check("t4_lto_once", lto_cnt, 32'd1);
      check("t4_no_clash", clash, 32'd0);

      // Core stalls before going active
      stall_left = 50;
      q0.push_back({1'b1, 8'h77});
      exp_q.push_back(8'h77);
      for (int i = 0; i < 20 && !dataTxStart; i++) begin @(posedge clk); #2; end
      check("t5_start", dataTxStart, 1'b1);
      r_base = rdy0 + rdy1;
      bad = 0;
      for (int i = 0; i < 45; i++) begin
         @(posedge clk); #2;
         if (dataTxStart !== 1'b1 || dataToTx !== 8'h77 || reqReady !== 2'b00 || lockTimeout !== 1'b0)
            bad++;
      end
      check("t5_stable", bad, 32'd0);
      check("t5_no_ready", rdy0 + rdy1 - r_base, 32'd0);
      check("t5_no_lto", lto_cnt, 32'd1);
      wait_idle("t5", 200);

      // Non-owner toggles valid during a 20-byte message
      en[1] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         q0.push_back({(i == 19), 8'(8'h60 + i)});
         exp_q.push_back(8'(8'h60 + i));
      end
      q1.push_back({1'b1, 8'h99});
      exp_q.push_back(8'h99);
      for (int i = 0; i < 20 && grant == 2'b00; i++) begin @(posedge clk); #2; end
      check("t6_grant_req0", grant, 2'b01);
      d_base = done_cnt;
      r1_base = rdy1;
      for (int i = 0; i < 600 && grant != 2'b10; i++) begin
         if (i % 3 == 0) en[1] = ~en[1];
         @(posedge clk); #2;
      end
      en[1] = 1'b1;
      check("t6_grant_req1", grant, 2'b10);
      check("t6_req0_done", done_cnt - d_base, 32'd20);
      check("t6_no_ready1", rdy1 - r1_base, 32'd0);
      wait_idle("t6", 200);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single serial transmitter (dataToTx/dataTxStart/dataTxActive/dataTxDone handshake) between NUM_REQ message sources, e.g. the RGB info protocol engine and a periodic status reporter.
- Grants are message-level and round-robin: once a requester owns the transmitter, it keeps it until it sends a byte flagged last, or until an inactivity timeout reclaims it.
- Sits between the requesters and the UART TX core, in the same clock domain.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..8.
- LOCK_TIMEOUT, 270000: idle cycles an owner may leave reqValid low mid-message before the lock is revoked (10 ms at 27 MHz); 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- reqValid  in  NUM_REQ  per-requester byte-valid.
- reqData  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- reqLast  in  NUM_REQ  marks the current byte as the last byte of the message.
- reqReady  out  NUM_REQ  one-cycle pulse: byte accepted from requester i.
- grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- busy  out  1  high whenever the arbiter is not in IDLE.
- lockTimeout  out  1  one-cycle pulse when a lock is revoked by timeout.
- dataToTx  out  8  byte to the UART TX core.
- dataTxStart  out  1  start request to the UART TX core.
- dataTxActive  in  1  UART TX core is shifting a byte.
- dataTxDone  in  1  one-cycle pulse at end of byte.

Behaviour:
- Reset (resetN low, asynchronous):
  - All outputs return to 0, including dataToTx=8'h00; dataTxStart drops immediately, even mid-byte.
  - FSM goes to IDLE; lastOwner=NUM_REQ-1, so requester 0 wins first; timer and lastFlag are cleared.
- States are IDLE, ISSUE, WAIT_ACTIVE and WAIT_DONE.
- IDLE:
  - If any reqValid bit is high, pick the first requester scanning from lastOwner+1, wrapping modulo NUM_REQ.
  - Set grant to that requester, set owner, clear the timer, go to ISSUE.
  - Grant appears one cycle after reqValid.
- ISSUE:
  - Condition: reqValid[owner]=1 and dataTxActive=0.
  - Actions: register dataToTx<=reqData[owner], dataTxStart<=1, pulse reqReady[owner] for 1 cycle, lastFlag<=reqLast[owner], clear the timer, go to WAIT_ACTIVE.
  - Otherwise, if reqValid[owner]=0 and LOCK_TIMEOUT>0, increment the timer.
  - When the timer reaches LOCK_TIMEOUT: grant<=0, lastOwner<=owner, pulse lockTimeout, go to IDLE.
- WAIT_ACTIVE:
  - Hold dataTxStart=1 and dataToTx stable until dataTxActive=1.
  - Then dataTxStart<=0 and go to WAIT_DONE.
  - No timeout in this state.
- WAIT_DONE:
  - On dataTxDone=1, or on dataTxActive falling to 0:
    - If lastFlag=1: grant<=0, lastOwner<=owner, go to IDLE.
    - Otherwise go to ISSUE.
  - Minimum inter-byte gap from the arbiter is 1 cycle.
- Ownership rules:
  - reqValid from non-owners is ignored while locked; their reqReady stays 0.
  - An owner dropping reqValid after its accepted byte is legal; it only runs the timer.
  - A byte with reqLast=1 ends the lock after that byte completes. A single-byte message (reqLast on the first byte) is legal.
- Fairness: the previous owner has lowest priority in the next IDLE arbitration, so with all requesters continuously valid, messages alternate 0,1,...,NUM_REQ-1,0.
- Widths and limits:
  - The timer is $clog2(LOCK_TIMEOUT+1) bits and saturates; it never wraps.
  - owner and lastOwner are $clog2(NUM_REQ) bits.
- Simultaneous events:
  - dataTxDone in the same cycle as a new reqValid is handled: the release happens first, and arbitration occurs in the following IDLE cycle.
  - reqReady is never asserted in the same cycle as lockTimeout.

Test Plan:
- Reset mid-byte:
  - Stimulus: req0 sends "A" (8'h41) and the core is active; assert resetN=0 for 3 cycles.
  - Required: dataTxStart=0 and grant=0 immediately. After release, req1 valid alone is granted first in scan order from lastOwner=NUM_REQ-1; with NUM_REQ=2, req1 is the only valid requester, so it is granted.
- Simultaneous start:
  - Stimulus: NUM_REQ=2; req0 message "ACK\r\n" (5 bytes, last on 8'h0a) and req1 message "NAK\r\n" both valid in the same cycle after reset.
  - Required: TX stream is exactly 41 43 4B 0D 0A 4E 41 4B 0D 0A; reqReady pulses 5 times for each requester.
- Fairness:
  - Stimulus: both requesters continuously send 1-byte messages (req0=8'h30, req1=8'h31, reqLast=1) for 6 messages.
  - Required: TX order is 30 31 30 31 30 31.
- Lock timeout:
  - Stimulus: LOCK_TIMEOUT=16; req0 sends 8'h31 with reqLast=0, then drops reqValid while req1 is valid.
  - Required: lockTimeout pulses exactly 16 cycles after the byte completes; req1 is granted on the next IDLE cycle.
- Core stall:
  - Stimulus: hold dataTxActive=0 for 50 cycles after start.
  - Required: dataTxStart and dataToTx stay stable; no reqReady pulse occurs; no timeout occurs.
- Non-owner during lock:
  - Stimulus: req1 toggles reqValid during req0's 20-byte message.
  - Required: reqReady[1] stays 0 throughout; grant[1] is asserted only after req0's last byte completes with dataTxDone.
